// File: rtl/cpu_pkg.sv
// Shared Mini SRC definitions: opcodes, control-step indices, sequencer states
// and the opcode-to-final-step lookup used by the sequencer and control decoder.
package cpu_pkg;

  localparam logic [4:0] OP_LD   = 5'b00000;
  localparam logic [4:0] OP_LDI  = 5'b00001;
  localparam logic [4:0] OP_ST   = 5'b00010;
  localparam logic [4:0] OP_ADD  = 5'b00011;
  localparam logic [4:0] OP_SUB  = 5'b00100;
  localparam logic [4:0] OP_AND  = 5'b00101;
  localparam logic [4:0] OP_OR   = 5'b00110;
  localparam logic [4:0] OP_ROR  = 5'b00111;
  localparam logic [4:0] OP_ROL  = 5'b01000;
  localparam logic [4:0] OP_SHR  = 5'b01001;
  localparam logic [4:0] OP_SHRA = 5'b01010;
  localparam logic [4:0] OP_SHL  = 5'b01011;
  localparam logic [4:0] OP_ADDI = 5'b01100;
  localparam logic [4:0] OP_ANDI = 5'b01101;
  localparam logic [4:0] OP_ORI  = 5'b01110;
  localparam logic [4:0] OP_MUL  = 5'b01111;
  localparam logic [4:0] OP_DIV  = 5'b10000;
  localparam logic [4:0] OP_NEG  = 5'b10001;
  localparam logic [4:0] OP_NOT  = 5'b10010;
  localparam logic [4:0] OP_BR   = 5'b10011;
  localparam logic [4:0] OP_JR   = 5'b10100;
  localparam logic [4:0] OP_JAL  = 5'b10101;
  localparam logic [4:0] OP_IN   = 5'b10110;
  localparam logic [4:0] OP_OUT  = 5'b10111;
  localparam logic [4:0] OP_MFHI = 5'b11000;
  localparam logic [4:0] OP_MFLO = 5'b11001;
  localparam logic [4:0] OP_NOP  = 5'b11010;
  localparam logic [4:0] OP_HALT = 5'b11011;

  localparam logic [2:0] T0 = 3'd0;
  localparam logic [2:0] T1 = 3'd1;
  localparam logic [2:0] T2 = 3'd2;
  localparam logic [2:0] T3 = 3'd3;
  localparam logic [2:0] T4 = 3'd4;
  localparam logic [2:0] T5 = 3'd5;
  localparam logic [2:0] T6 = 3'd6;
  localparam logic [2:0] T7 = 3'd7;

  typedef enum logic [1:0] {
    S_RST  = 2'd0,
    S_RUN  = 2'd1,
    S_WAIT = 2'd2,
    S_HALT = 2'd3
  } seq_state_t;

  // Undefined opcodes fall into the default and run as a nop.
  function automatic logic [2:0] instr_last_step(input logic [4:0] op);
    logic [2:0] last;
    case (op)
      OP_LD, OP_LDI, OP_ST:                         last = T7;
      OP_ADD, OP_SUB, OP_AND, OP_OR, OP_ROR,
      OP_ROL, OP_SHR, OP_SHRA, OP_SHL:              last = T5;
      OP_ADDI, OP_ANDI, OP_ORI, OP_NEG, OP_NOT:     last = T5;
      OP_MUL, OP_DIV, OP_BR:                        last = T6;
      OP_JAL:                                       last = T4;
      default:                                      last = T3;
    endcase
    return last;
  endfunction

endpackage

// File: rtl/step_len_decode.sv
// Combinational opcode -> final control step lookup, plus halt-opcode flag.
module step_len_decode
  import cpu_pkg::*;
(
  input  logic [4:0] opcode,
  output logic [2:0] last_step,
  output logic       is_halt
);

  assign last_step = instr_last_step(opcode);
  assign is_halt   = (opcode == OP_HALT);

endmodule

// File: rtl/step_sequencer.sv
// Mini SRC control-step generator: one-hot T0-T7, memory-ready stall, halt/stop.
// Optional macro STEP_SINGLE_STEP_EN adds step_req for edge-triggered single stepping.
module step_sequencer
  import cpu_pkg::*;
#(
  parameter int NSTEPS = 8
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              stop,
  input  logic [4:0]        opcode,
  input  logic              mem_ready,
`ifdef STEP_SINGLE_STEP_EN
  input  logic              step_req,
`endif
  output logic [NSTEPS-1:0] step,
  output logic              run,
  output logic              instr_done,
  output logic              halted
);

  seq_state_t        state_q, state_d;
  logic [2:0]        idx_q, idx_d;
  logic [2:0]        last_q, last_nx, len_dec;
  logic              halt_op_q, halt_dec;
  logic              stop_pend_q;
  logic              load_len;
  logic              adv;
  logic              at_final;

  logic [NSTEPS-1:0] step_d;
  logic              run_d, done_d, halted_d;
  logic [NSTEPS-1:0] step_q;
  logic              run_q, done_q, halted_q;

  step_len_decode u_len (
    .opcode    (opcode),
    .last_step (len_dec),
    .is_halt   (halt_dec)
  );

`ifdef STEP_SINGLE_STEP_EN
  logic req_prev_q;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      req_prev_q <= 1'b0;
    end else begin
      req_prev_q <= step_req;
    end
  end

  assign adv = step_req & ~req_prev_q;
`else
  assign adv = 1'b1;
`endif

  // Step index is binary; last_q is only meaningful from T3 onward and always >= T3,
  // so it can never match T0-T2 of the following instruction.
  assign at_final = (idx_q == last_q);

  // State register
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q     <= S_RST;
      idx_q       <= T0;
      last_q      <= T7;
      halt_op_q   <= 1'b0;
      stop_pend_q <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      if (load_len) begin
        last_q    <= len_dec;
        halt_op_q <= halt_dec;
      end
      if (stop && (state_q != S_HALT)) begin
        stop_pend_q <= 1'b1;
      end
    end
  end

  // Next-state logic. The length class is sampled on the edge that enters T3 so
  // that instr_done can already be registered for a three-step instruction.
  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    load_len = 1'b0;
    case (state_q)
      S_RST: begin
        state_d = S_RUN;
        idx_d   = T0;
      end
      S_RUN: begin
        if (adv) begin
          if (at_final) begin
            // A stop arriving on the final edge still wins over the next T0.
            if (halt_op_q || stop_pend_q || stop) begin
              state_d = S_HALT;
            end else begin
              idx_d = T0;
            end
          end else if (idx_q == T1) begin
            if (mem_ready) begin
              idx_d = T2;
            end else begin
              state_d = S_WAIT;
            end
          end else begin
            idx_d    = idx_q + 3'd1;
            load_len = (idx_q == T2);
          end
        end
      end
      S_WAIT: begin
        if (mem_ready) begin
          state_d = S_RUN;
          idx_d   = T2;
        end
      end
      S_HALT: begin
        state_d = S_HALT;
      end
      default: begin
        state_d = S_RST;
        idx_d   = T0;
      end
    endcase
  end

  // Output logic: computed from the next state so every output is a flop.
  always_comb begin
    last_nx  = load_len ? len_dec : last_q;
    run_d    = (state_d == S_RUN) || (state_d == S_WAIT);
    halted_d = (state_d == S_HALT);
    done_d   = (state_d == S_RUN) && (idx_d == last_nx);
    step_d   = '0;
    for (int i = 0; i < NSTEPS; i++) begin
      step_d[i] = run_d && (idx_d == i[2:0]);
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      step_q   <= '0;
      run_q    <= 1'b0;
      done_q   <= 1'b0;
      halted_q <= 1'b0;
    end else begin
      step_q   <= step_d;
      run_q    <= run_d;
      done_q   <= done_d;
      halted_q <= halted_d;
    end
  end

  assign step       = step_q;
  assign run        = run_q;
  assign instr_done = done_q;
  assign halted     = halted_q;

endmodule

// File: tb/tb_step_sequencer.sv
// Self-checking bench for step_sequencer: directed literal sequences plus random traffic
// checked every cycle against an instruction-level behavioural model.
module tb_step_sequencer;

  logic       clock = 1'b0;
  logic       reset;
  logic       stop;
  logic [4:0] opcode;
  logic       mem_ready;
  logic       step_req;
  logic [7:0] step;
  logic       run;
  logic       instr_done;
  logic       halted;

  int total = 0;
  int bad   = 0;
  bit chk_en = 1'b0;

  // Model state: position within the current instruction (-1 = not sequencing).
  int m_pos;
  int m_len;
  bit m_halt;
  bit m_stop;
  bit m_ophalt;

  step_sequencer #(.NSTEPS(8)) dut (
    .clock      (clock),
    .reset      (reset),
    .stop       (stop),
    .opcode     (opcode),
    .mem_ready  (mem_ready),
`ifdef STEP_SINGLE_STEP_EN
    .step_req   (step_req),
`endif
    .step       (step),
    .run        (run),
    .instr_done (instr_done),
    .halted     (halted)
  );

  always #5 clock = ~clock;

  function automatic int len_of(input int op);
    if (op <= 2)       return 7;
    else if (op <= 14) return 5;
    else if (op <= 16) return 6;
    else if (op <= 18) return 5;
    else if (op == 19) return 6;
    else if (op == 21) return 4;
    else               return 3;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(posedge clock or negedge reset) begin : model
    int p, l;
    bit h, s, oh;
    if (!reset) begin
      m_pos    <= -1;
      m_len    <= 7;
      m_halt   <= 1'b0;
      m_stop   <= 1'b0;
      m_ophalt <= 1'b0;
    end else begin
      p = m_pos; l = m_len; h = m_halt; s = m_stop; oh = m_ophalt;
      if (!h) begin
        if (stop) s = 1'b1;
        if (p < 0) begin
          p = 0;
        end else if (p >= 3 && p == l) begin
          if (oh || s) begin
            h = 1'b1;
            p = -1;
          end else begin
            p = 0;
          end
        end else if (p == 1 && !mem_ready) begin
          p = 1;
        end else begin
          p = p + 1;
          if (p == 3) begin
            l  = len_of(int'(opcode));
            oh = (opcode == 5'd27);
          end
        end
      end
      m_pos    <= p;
      m_len    <= l;
      m_halt   <= h;
      m_stop   <= s;
      m_ophalt <= oh;
    end
  end

  always @(negedge clock) begin
    if (chk_en) begin
      chk("model_step", step, (m_pos >= 0) ? (32'd1 << m_pos) : 32'd0);
      chk("model_run", run, m_pos >= 0);
      chk("model_done", instr_done, (m_pos >= 3) && (m_pos == m_len));
      chk("model_halted", halted, m_halt);
    end
  end

  task automatic do_reset();
    reset = 1'b0;
    repeat (2) @(negedge clock);
    reset = 1'b1;
  endtask

  initial begin
    reset = 1'b0; stop = 1'b0; mem_ready = 1'b1; opcode = 5'd3; step_req = 1'b0;
    repeat (2) @(posedge clock);
    @(negedge clock);
    chk_en = 1'b1;
    chk("rst_step", step, 8'h00);
    chk("rst_run", run, 1'b0);
    chk("rst_done", instr_done, 1'b0);
    chk("rst_halted", halted, 1'b0);

    // add: T0..T5, done only on T5, then T0
    reset = 1'b1;
    #1 chk("pre_t0", step, 8'h00);
    for (int k = 0; k <= 5; k++) begin
      @(negedge clock);
      chk("add_step", step, 8'h01 << k);
      chk("add_done", instr_done, k == 5);
    end
    @(negedge clock);
    chk("add_next", step, 8'h01);
    chk("add_run", run, 1'b1);

    // ld with mem_ready low on three T1 edges
    opcode = 5'd0; mem_ready = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clock);
      chk("ld_stall", step, 8'h02);
      chk("ld_stall_done", instr_done, 1'b0);
    end
    mem_ready = 1'b1;
    for (int k = 2; k <= 7; k++) begin
      @(negedge clock);
      chk("ld_step", step, 8'h01 << k);
      chk("ld_done", instr_done, k == 7);
    end
    @(negedge clock);
    chk("ld_next", step, 8'h01);

    // mul with a stop pulse in T2
    opcode = 5'b01111;
    @(negedge clock);
    @(negedge clock);
    chk("mul_t2", step, 8'h04);
    stop = 1'b1;
    @(negedge clock);
    stop = 1'b0;
    chk("mul_t3", step, 8'h08);
    @(negedge clock);
    @(negedge clock);
    @(negedge clock);
    chk("mul_t6", step, 8'h40);
    chk("mul_done", instr_done, 1'b1);
    @(negedge clock);
    chk("mul_halt_step", step, 8'h00);
    chk("mul_halt_run", run, 1'b0);
    chk("mul_halt_halted", halted, 1'b1);
    chk("mul_halt_done", instr_done, 1'b0);

    // halt opcode, then inputs toggled while halted
    opcode = 5'd27;
    do_reset();
    @(negedge clock);
    chk("halt_t0", step, 8'h01);
    @(negedge clock);
    @(negedge clock);
    @(negedge clock);
    chk("halt_t3", step, 8'h08);
    chk("halt_done", instr_done, 1'b1);
    @(negedge clock);
    chk("halt_halted", halted, 1'b1);
    for (int k = 0; k < 10; k++) begin
      mem_ready = 1'($urandom_range(0, 1));
      stop      = 1'($urandom_range(0, 1));
      opcode    = 5'($urandom_range(0, 31));
      @(negedge clock);
      chk("halt_hold_step", step, 8'h00);
      chk("halt_hold_run", run, 1'b0);
      chk("halt_hold_halted", halted, 1'b1);
    end
    stop = 1'b0; mem_ready = 1'b1;

    // st: stop in T1, async reset in T4 discards the pending stop
    opcode = 5'd2;
    do_reset();
    @(negedge clock);
    chk("st_t0", step, 8'h01);
    @(negedge clock);
    stop = 1'b1;
    @(negedge clock);
    stop = 1'b0;
    @(negedge clock);
    @(negedge clock);
    chk("st_t4", step, 8'h10);
    #2 reset = 1'b0;
    #1;
    chk("st_arst_step", step, 8'h00);
    chk("st_arst_run", run, 1'b0);
    chk("st_arst_done", instr_done, 1'b0);
    @(negedge clock);
    reset = 1'b1;
    for (int k = 0; k <= 7; k++) begin
      @(negedge clock);
      chk("st_again", step, 8'h01 << k);
    end
    @(negedge clock);
    chk("st_no_stale_stop", step, 8'h01);
    chk("st_no_stale_halted", halted, 1'b0);

    // random traffic
    for (int c = 0; c < 4000; c++) begin
      @(negedge clock);
      if (m_pos == 0) begin
        if ($urandom_range(0, 15) == 0) opcode = 5'd27;
        else                            opcode = 5'($urandom_range(0, 31));
      end
      mem_ready = ($urandom_range(0, 9) < 6);
      stop      = ($urandom_range(0, 199) == 0);
      if ((m_halt && $urandom_range(0, 3) == 0) || $urandom_range(0, 299) == 0) begin
        #($urandom_range(1, 4));
        reset = 1'b0;
        @(negedge clock);
        if ($urandom_range(0, 1) == 1) @(negedge clock);
        reset = 1'b1;
      end
    end

    chk_en = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
